id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage directly downstream of the fetch stage. Consumes the 32-bit IR
//  from the IF/ID register and decodes MIPS-style fields. Reads a 32x32
//  register file and registers operands, the immediate and control into an
//  ID/EX pipeline register. Detects load-use hazards and stalls fetch; accepts
//  a flush from EX and accepts the WB write port.
// PARAMETERS
//  DATA_W    32  register/operand width
//  REG_NUM   32  register file depth (r0 hardwired to zero)
//  ALUOP_W    4  width of ex_alu_op
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous reset, active-high
//  if_valid     in   1        IR holds a real instruction
//  IR           in   32       instruction from IF/ID register
//  flush        in   1        EX redirect; squash the instruction in ID
//  wb_we        in   1        write-back enable
//  wb_addr      in   5        write-back register index
//  wb_data      in   DATA_W   write-back data
//  stall        out  1        hold PC and IF/ID this cycle (combinational)
//  ex_valid     out  1        ID/EX entry is a real instruction
//  ex_rs_data   out  DATA_W   operand A
//  ex_rt_data   out  DATA_W   operand B / store data
//  ex_imm       out  DATA_W   sign-extended IR[15:0]
//  ex_rs        out  5        rs index (for EX forwarding)
//  ex_rt        out  5        rt index
//  ex_dest      out  5        destination (rd for R-type, rt for I-type)
//  ex_alu_op    out  ALUOP_W  ALU function code
//  ex_ctrl      out  5        {reg_write, mem_read, mem_write, alu_src, branch}
// BEHAVIOUR
//  - Reset: every regfile entry = 0; all ex_* = 0; ex_valid = 0.
//  - Fields: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], funct=IR[5:0].
//  - Decode:
//      op 0x00: R-type; alu_op from funct
//               add 0x20->0, sub 0x22->1, and 0x24->2, or 0x25->3, slt 0x2A->4
//      op 0x08: addi -> alu_op 0
//      op 0x23: lw   -> alu_op 0
//      op 0x2B: sw   -> alu_op 0
//      op 0x04: beq  -> alu_op 1
//  - Unknown op/funct: NOP (ex_ctrl = 0, ex_valid follows if_valid).
//  - Regfile: 2 comb reads, 1 write on posedge when wb_we && wb_addr != 0.
//    Reading r0 always returns 0.
//  - Hazard: stall = if_valid & ex_valid & ex_ctrl.mem_read & (ex_dest != 0)
//      & (ex_dest == rs | (ex_dest == rt & IR uses rt as source)) & !flush.
//    Sources: R-type, sw and beq use rt; addi and lw do not.
//  - ID/EX update, one-cycle latency, priority highest first:
//      1. rst:   clear all outputs.
//      2. flush: ex_valid <= 0, ex_ctrl <= 0 (flush overrides stall).
//      3. stall: insert bubble (ex_valid <= 0, ex_ctrl <= 0); IR is re-decoded
//         next cycle.
//      4. else:  load decoded fields; ex_valid <= if_valid; ex_ctrl <= 0 when
//         !if_valid.
//  - Bubbles keep data fields don't-care; the bench checks them only when ex_valid=1.
//  - Reset mid-stall: stall drops the same cycle rst is sampled; no pending state.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    A read of wb_addr (!=0) while wb_we=1 returns wb_data in the same cycle
//    (write-before-read).
//  Undefined:
//    That read returns the old register value. The WB->ID hazard then needs
//    software/NOP spacing.
// TESTING
//  1. Reset then IR=addi r1,r0,5 (0x20010005):
//     next cycle ex_valid=1, ex_imm=5, ex_dest=1, ex_ctrl=5'b10010.
//  2. WB write r3=0xDEADBEEF, then IR=add r4,r3,r3:
//     ex_rs_data = ex_rt_data = 0xDEADBEEF.
//     Same-cycle write/read: bypass value if REGFILE_BYPASS_EN, old value otherwise.
//  3. lw r2,0(r1) followed by add r5,r2,r1:
//     stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then add issues.
//  4. lw r2 then addi r6,r2,1:
//     stall=1 (rs match).
//     lw r2 then addi r2,r7,1: stall=0 (rt not a source).
//  5. flush=1 during a stall cycle:
//     stall=0, ex_valid=0 next cycle.
//     Write r0=0x1234: reads of r0 stay 0.
//  6. IR=0xFC000000 (unknown op), if_valid=1:
//     ex_valid=1, ex_ctrl=0. if_valid=0 -> ex_valid=0.

Source files
------------

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- MIPS-style instruction decode stage
//
// Decodes the instruction held in the IF/ID register and reads two operands
// from a 32x32 register file (r0 reads as zero). It registers the operands,
// the sign-extended immediate, the register indices and the control bits into
// the ID/EX pipeline register. It detects load-use hazards against the
// instruction in ID/EX, stalls fetch and inserts a bubble. It accepts a flush
// from EX and the write-back port from WB.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  defined   : a read of wb_addr (!= 0) while wb_we=1
//                                  returns wb_data in the same cycle
//                      undefined : that read returns the old register value
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   if_valid, IR  instruction from the IF/ID register and its valid flag
//   flush         squash the instruction in ID (takes priority over stall)
//   wb_we/addr/data  register file write port
//   stall         combinational hold request for PC and IF/ID
//   ex_*          ID/EX register; ex_ctrl = {reg_write, mem_read, mem_write,
//                 alu_src, branch}
// -----------------------------------------------------------------------------
module id_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_NUM = 32,
   parameter int ALUOP_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_valid,
   input  logic [31:0]        IR,
   input  logic               flush,
   input  logic               wb_we,
   input  logic [4:0]         wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               stall,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_rs_data,
   output logic [DATA_W-1:0]  ex_rt_data,
   output logic [DATA_W-1:0]  ex_imm,
   output logic [4:0]         ex_rs,
   output logic [4:0]         ex_rt,
   output logic [4:0]         ex_dest,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic [4:0]         ex_ctrl
);

   // Opcodes and R-type function codes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic alu_src;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP  = '0;
   localparam ctrl_t CTRL_R    = '{reg_write: 1'b1, default: 1'b0};
   localparam ctrl_t CTRL_ADDI = '{reg_write: 1'b1, alu_src: 1'b1, default: 1'b0};
   localparam ctrl_t CTRL_LW   = '{reg_write: 1'b1, mem_read: 1'b1, alu_src: 1'b1, default: 1'b0};
   localparam ctrl_t CTRL_SW   = '{mem_write: 1'b1, alu_src: 1'b1, default: 1'b0};
   localparam ctrl_t CTRL_BEQ  = '{branch: 1'b1, default: 1'b0};

   // Instruction fields
   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [5:0] funct;

   assign op    = IR[31:26];
   assign rs    = IR[25:21];
   assign rt    = IR[20:16];
   assign rd    = IR[15:11];
   assign funct = IR[5:0];

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   ctrl_t              dec_ctrl;
   logic [ALUOP_W-1:0] dec_alu_op;
   logic [4:0]         dec_dest;
   logic               dec_uses_rt;
   logic [DATA_W-1:0]  dec_imm;

   assign dec_imm = {{(DATA_W-16){IR[15]}}, IR[15:0]};

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      dec_ctrl    = CTRL_NOP;
      dec_alu_op  = ALU_ADD;
      dec_dest    = rt;
      dec_uses_rt = 1'b0;
      case (op)
         OP_RTYPE: begin
            dec_dest    = rd;
            dec_uses_rt = 1'b1;
            dec_ctrl    = CTRL_R;
            case (funct)
               FN_ADD:  dec_alu_op = ALU_ADD;
               FN_SUB:  dec_alu_op = ALU_SUB;
               FN_AND:  dec_alu_op = ALU_AND;
               FN_OR:   dec_alu_op = ALU_OR;
               FN_SLT:  dec_alu_op = ALU_SLT;
               default: dec_ctrl   = CTRL_NOP;
            endcase
         end
         OP_ADDI: dec_ctrl = CTRL_ADDI;
         OP_LW:   dec_ctrl = CTRL_LW;
         OP_SW: begin
            dec_ctrl    = CTRL_SW;
            dec_uses_rt = 1'b1;
         end
         OP_BEQ: begin
            dec_ctrl    = CTRL_BEQ;
            dec_alu_op  = ALU_SUB;
            dec_uses_rt = 1'b1;
         end
         default: dec_ctrl = CTRL_NOP;
      endcase
   end

   // ---------------------------------------------------------------------
   // Register file: two combinational reads, one write port
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] regs [REG_NUM];
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;

   always_ff @(posedge clk) begin
      // NOTE: this memory is explicitly cleared on reset because software
      // relies on every register reading zero after reset; this keeps it
      // in flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (wb_we && wb_addr != 5'd0) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         regs[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rs_data = (rs == 5'd0) ? '0 : regs[rs];
      rt_data = (rt == 5'd0) ? '0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
      // Write-before-read: forward the value being written this cycle.
      if (wb_we && wb_addr != 5'd0 && wb_addr == rs) rs_data = wb_data;
      if (wb_we && wb_addr != 5'd0 && wb_addr == rt) rt_data = wb_data;
`endif
   end

   // ---------------------------------------------------------------------
   // Load-use hazard: the load in ID/EX writes a register this instruction
   // reads. A flush squashes the consumer, so there is nothing to wait for.
   // ---------------------------------------------------------------------
   ctrl_t ex_ctrl_q;

   assign ex_ctrl = ex_ctrl_q;

   assign stall = !rst && !flush && if_valid && ex_valid && ex_ctrl_q.mem_read
                  && (ex_dest != 5'd0)
                  && ((ex_dest == rs) || ((ex_dest == rt) && dec_uses_rt));

   // ---------------------------------------------------------------------
   // ID/EX pipeline register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_dest    <= '0;
         ex_alu_op  <= '0;
         ex_ctrl_q  <= CTRL_NOP;
      end else if (flush || stall) begin
         // Bubble: data fields are left as they are, only the entry is killed.
         ex_valid  <= 1'b0;
         ex_ctrl_q <= CTRL_NOP;
      end else begin
         ex_valid   <= if_valid;
         ex_rs_data <= rs_data;
         ex_rt_data <= rt_data;
         ex_imm     <= dec_imm;
         ex_rs      <= rs;
         ex_rt      <= rt;
         ex_dest    <= dec_dest;
         ex_alu_op  <= dec_alu_op;
         ex_ctrl_q  <= if_valid ? dec_ctrl : CTRL_NOP;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- scoreboard bench for id_stage
//
// The driver applies one directed vector per cycle and pushes the expected
// stall (for that cycle) and the expected ID/EX contents (visible after the
// following edge) into two queues. A monitor on the falling edge pops and
// compares whatever is pending.
// -----------------------------------------------------------------------------
module tb_id_stage;

   typedef struct {
      logic        valid;
      logic        chk;     // compare data fields too
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [3:0]  alu;
      logic [4:0]  ctrl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] ir;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rs;
   logic [4:0]  ex_rt;
   logic [4:0]  ex_dest;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_ctrl;

   int errors = 0;
   int checks = 0;

   logic stall_q[$];
   exp_t ex_q[$];

   id_stage dut (
      .clk        (clk),
      .rst        (rst),
      .if_valid   (if_valid),
      .IR         (ir),
      .flush      (flush),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .stall      (stall),
      .ex_valid   (ex_valid),
      .ex_rs_data (ex_rs_data),
      .ex_rt_data (ex_rt_data),
      .ex_imm     (ex_imm),
      .ex_rs      (ex_rs),
      .ex_rt      (ex_rt),
      .ex_dest    (ex_dest),
      .ex_alu_op  (ex_alu_op),
      .ex_ctrl    (ex_ctrl)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [31:0] rsd, rtd, imm,
                               input logic [4:0] rs, rt, dest,
                               input logic [3:0] alu, input logic [4:0] ctrl);
      exp_t e;
      e.valid = v;   e.chk = 1'b1;
      e.rsd = rsd;   e.rtd = rtd;  e.imm = imm;
      e.rs = rs;     e.rt = rt;    e.dest = dest;
      e.alu = alu;   e.ctrl = ctrl;
      return e;
   endfunction

   // Entry whose data fields are don't-care; only valid and ctrl are compared.
   function automatic exp_t vc(input logic v, input logic [4:0] ctrl);
      exp_t e;
      e = mk(v, '0, '0, '0, '0, '0, '0, '0, ctrl);
      e.chk = 1'b0;
      return e;
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (ex_q.size() > 0) begin
         exp_t e;
         e = ex_q.pop_front();
         check("ex_valid", ex_valid, e.valid);
         check("ex_ctrl", ex_ctrl, e.ctrl);
         if (e.chk) begin
            check("ex_rs_data", ex_rs_data, e.rsd);
            check("ex_rt_data", ex_rt_data, e.rtd);
            check("ex_imm", ex_imm, e.imm);
            check("ex_rs", ex_rs, e.rs);
            check("ex_rt", ex_rt, e.rt);
            check("ex_dest", ex_dest, e.dest);
            check("ex_alu_op", ex_alu_op, e.alu);
         end
      end
      if (stall_q.size() > 0) begin
         logic s;
         s = stall_q.pop_front();
         check("stall", stall, s);
      end
   end

   // One cycle: drive inputs, expect stall now and e after the next edge.
   task automatic step(input logic r, v, input logic [31:0] instr, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic es, input exp_t e);
      rst = r; if_valid = v; ir = instr; flush = fl;
      wb_we = we; wb_addr = wa; wb_data = wd;
      stall_q.push_back(es);
      @(posedge clk);
      #1;
      ex_q.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r5_same_cycle;
      exp_t lw_e;
`ifdef REGFILE_BYPASS_EN
      r5_same_cycle = 32'h1234_5678;
`else
      r5_same_cycle = 32'h0;
`endif
      lw_e = mk(1, 32'h100, 0, 0, 1, 2, 2, 0, 5'b11010);

      rst = 1'b1; if_valid = 1'b0; ir = '0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      @(posedge clk);
      #1;

      // Reset: everything cleared
      step(1, 0, 32'h0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00000));
      // addi r1,r0,5 while WB writes r3
      step(0, 1, 32'h2001_0005, 0, 1, 3, 32'hDEAD_BEEF, 0,
           mk(1, 0, 0, 5, 0, 1, 1, 0, 5'b10010));
      // add r4,r3,r3 while WB writes r1
      step(0, 1, 32'h0063_2020, 0, 1, 1, 32'h0000_0100, 0,
           mk(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h2020, 3, 3, 4, 0, 5'b10000));
      // sub r6,r5,r3 with same-cycle WB write of r5
      step(0, 1, 32'h00A3_3022, 0, 1, 5, 32'h1234_5678, 0,
           mk(1, r5_same_cycle, 32'hDEAD_BEEF, 32'h3022, 5, 3, 6, 1, 5'b10000));
      // lw r2,0(r1); add r5,r2,r1 -> one stall, one bubble, then add
      step(0, 1, 32'h8C22_0000, 0, 0, 0, 0, 0, lw_e);
      step(0, 1, 32'h0041_2820, 0, 0, 0, 0, 1, vc(0, 5'b00000));
      step(0, 1, 32'h0041_2820, 0, 0, 0, 0, 0,
           mk(1, 0, 32'h100, 32'h2820, 2, 1, 5, 0, 5'b10000));
      // lw r2; addi r6,r2,1 -> rs match stalls (WB writes r7 meanwhile)
      step(0, 1, 32'h8C22_0000, 0, 1, 7, 32'hCAFE_F00D, 0, lw_e);
      step(0, 1, 32'h2046_0001, 0, 0, 0, 0, 1, vc(0, 5'b00000));
      step(0, 1, 32'h2046_0001, 0, 0, 0, 0, 0,
           mk(1, 0, 0, 1, 2, 6, 6, 0, 5'b10010));
      // lw r2; addi r2,r7,1 -> rt is not a source, no stall
      step(0, 1, 32'h8C22_0000, 0, 0, 0, 0, 0, lw_e);
      step(0, 1, 32'h20E2_0001, 0, 0, 0, 0, 0,
           mk(1, 32'hCAFE_F00D, 0, 1, 7, 2, 2, 0, 5'b10010));
      // lw r2; and r8,r1,r2 -> rt match on R-type stalls
      step(0, 1, 32'h8C22_0000, 0, 0, 0, 0, 0, lw_e);
      step(0, 1, 32'h0022_4024, 0, 0, 0, 0, 1, vc(0, 5'b00000));
      step(0, 1, 32'h0022_4024, 0, 0, 0, 0, 0,
           mk(1, 32'h100, 0, 32'h4024, 1, 2, 8, 2, 5'b10000));
      // lw r2; or r9,r2,r3 with flush -> no stall, squashed; WB tries r0
      step(0, 1, 32'h8C22_0000, 0, 0, 0, 0, 0, lw_e);
      step(0, 1, 32'h0043_4825, 1, 1, 0, 32'h1234, 0, vc(0, 5'b00000));
      // slt r10,r0,r3 while WB tries r0 again: r0 reads zero
      step(0, 1, 32'h0003_502A, 0, 1, 0, 32'h1234, 0,
           mk(1, 0, 32'hDEAD_BEEF, 32'h502A, 0, 3, 10, 4, 5'b10000));
      // sw r3,-4(r1)
      step(0, 1, 32'hAC23_FFFC, 0, 0, 0, 0, 0,
           mk(1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1, 3, 3, 0, 5'b00110));
      // beq r1,r3,-32768
      step(0, 1, 32'h1023_8000, 0, 0, 0, 0, 0,
           mk(1, 32'h100, 32'hDEAD_BEEF, 32'hFFFF_8000, 1, 3, 3, 1, 5'b00001));
      // Unknown opcode -> valid NOP
      step(0, 1, 32'hFC00_0000, 0, 0, 0, 0, 0, vc(1, 5'b00000));
      // if_valid=0 -> invalid entry
      step(0, 0, 32'h0063_2020, 0, 0, 0, 0, 0, vc(0, 5'b00000));
      // Unknown funct -> valid NOP
      step(0, 1, 32'h0000_003F, 0, 0, 0, 0, 0, vc(1, 5'b00000));
      // lw r2 then a dependent IR that is not valid -> no stall
      step(0, 1, 32'h8C22_0000, 0, 0, 0, 0, 0, lw_e);
      step(0, 0, 32'h0041_2820, 0, 0, 0, 0, 0, vc(0, 5'b00000));

      if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;
      @(negedge clk);
      #1;
      check("queues_drained", stall_q.size() + ex_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
